// File: rtl/execute_stage.sv
// Execute stage of the pipelined MIPS core: single-cycle ALU, iterative unsigned
// multiply/divide with HI/LO, EX/MEM output register and upstream stall.
module execute_stage #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_flush,
    input  logic [25:0]      i_imm,
    input  logic [WIDTH-1:0] i_busA,
    input  logic [WIDTH-1:0] i_busB,
    input  logic [4:0]       i_Rw,
    input  logic [8:0]       i_EX,
    input  logic [2:0]       i_M,
    input  logic             i_WB,
    output logic             o_stall,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_busB,
    output logic             o_zero,
    output logic [4:0]       o_Rw,
    output logic [2:0]       o_M,
    output logic             o_WB
);

    localparam int CW = $clog2(MD_CYCLES);
    localparam logic [CW-1:0] LAST_ITER = CW'(MD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]     opnd_r;
    logic                 is_div_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic [3:0]           alu_op_s;
    logic [1:0]           md_op_s;
    logic                 md_req_s;
    logic                 md_start_s;
    logic [WIDTH-1:0]     ext_imm_s;
    logic [WIDTH-1:0]     opb_s;
    logic [4:0]           shamt_s;
    logic [WIDTH-1:0]     alu_res_s;

    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic                 div_ge_s;
    logic                 unused_s;

    assign alu_op_s   = i_EX[3:0];
    assign md_op_s    = i_EX[8:7];
    assign md_req_s   = (md_op_s == 2'b01) || (md_op_s == 2'b10);
    assign md_start_s = (state_r == IDLE) && i_valid && md_req_s && !i_flush;
    assign ext_imm_s  = i_EX[5] ? {{(WIDTH-16){i_imm[15]}}, i_imm[15:0]}
                                : {{(WIDTH-16){1'b0}}, i_imm[15:0]};
    assign opb_s      = i_EX[4] ? ext_imm_s : i_busB;
    assign shamt_s    = i_EX[6] ? i_imm[10:6] : i_busA[4:0];
    assign unused_s   = ^{i_imm[25:16], div_diff_s[WIDTH]};

    // Combinational ALU
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (alu_op_s)
            4'd0:    alu_res_s = i_busA + opb_s;
            4'd1:    alu_res_s = i_busA - opb_s;
            4'd2:    alu_res_s = i_busA & opb_s;
            4'd3:    alu_res_s = i_busA | opb_s;
            4'd4:    alu_res_s = i_busA ^ opb_s;
            4'd5:    alu_res_s = ~(i_busA | opb_s);
            4'd6:    alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(i_busA) < $signed(opb_s))};
            4'd7:    alu_res_s = {{(WIDTH-1){1'b0}}, (i_busA < opb_s)};
            4'd8:    alu_res_s = i_busB << shamt_s;
            4'd9:    alu_res_s = i_busB >> shamt_s;
            4'd10:   alu_res_s = $signed(i_busB) >>> shamt_s;
            4'd11:   alu_res_s = {i_imm[15:0], 16'h0000};
            4'd12:   alu_res_s = hi_r;
            4'd13:   alu_res_s = lo_r;
            default: alu_res_s = i_busA;
        endcase
    end

    // One radix-2 iteration: acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        div_ge_s    = div_shift_s >= {1'b0, opnd_r};
        acc_next_s  = acc_r;
        if (is_div_r) begin
            if (div_ge_s) begin
                acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Next-state and stall decode
    always_comb begin
        state_s = state_r;
        o_stall = 1'b0;
        if (i_rst) begin
            state_s = IDLE;
        end else if (i_flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (md_start_s) begin
                        state_s = BUSY;
                        o_stall = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BUSY: begin
                    o_stall = 1'b1;
                    if (cnt_r == LAST_ITER) begin
                        state_s = DONE;
                    end else begin
                        state_s = BUSY;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Multiply/divide operand latch and iteration datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else if (md_start_s) begin
            is_div_r <= md_op_s[1];
            opnd_r   <= md_op_s[1] ? i_busB : i_busA;
            acc_r    <= {{WIDTH{1'b0}}, (md_op_s[1] ? i_busA : i_busB)};
            cnt_r    <= {CW{1'b0}};
        end else if ((state_r == BUSY) && !i_flush) begin
            acc_r    <= acc_next_s;
            cnt_r    <= cnt_r + CW'(1);
        end else begin
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
        end
    end

    // HI/LO commit on the completion cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if ((state_r == DONE) && !i_flush) begin
            hi_r <= acc_r[2*WIDTH-1:WIDTH];
            lo_r <= acc_r[WIDTH-1:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // EX/MEM register; bubbles clear valid/M/WB and hold the data fields
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_result <= {WIDTH{1'b0}};
            o_busB   <= {WIDTH{1'b0}};
            o_zero   <= 1'b0;
            o_Rw     <= 5'd0;
            o_M      <= 3'd0;
            o_WB     <= 1'b0;
        end else if (!i_flush && (state_r == DONE)) begin
            o_valid  <= 1'b1;
            o_result <= acc_r[WIDTH-1:0];
            o_busB   <= i_busB;
            o_zero   <= (acc_r[WIDTH-1:0] == {WIDTH{1'b0}});
            o_Rw     <= i_Rw;
            o_M      <= i_M;
            o_WB     <= i_WB;
        end else if (!i_flush && (state_r == IDLE) && i_valid && !md_start_s) begin
            o_valid  <= 1'b1;
            o_result <= alu_res_s;
            o_busB   <= i_busB;
            o_zero   <= (alu_res_s == {WIDTH{1'b0}});
            o_Rw     <= i_Rw;
            o_M      <= i_M;
            o_WB     <= i_WB;
        end else begin
            o_valid  <= 1'b0;
            o_M      <= 3'd0;
            o_WB     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: random and directed ALU / MULTU / DIVU traffic
// checked against an arithmetic reference model of the EX/MEM output stream.
module tb_execute_stage;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        i_flush;
    logic [25:0] i_imm;
    logic [31:0] i_busA;
    logic [31:0] i_busB;
    logic [4:0]  i_Rw;
    logic [8:0]  i_EX;
    logic [2:0]  i_M;
    logic        i_WB;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_result;
    logic [31:0] o_busB;
    logic        o_zero;
    logic [4:0]  o_Rw;
    logic [2:0]  o_M;
    logic        o_WB;

    typedef struct {
        logic [31:0] res;
        logic [31:0] busb;
        logic        zero;
        logic [4:0]  rw;
        logic [2:0]  m;
        logic        wb;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    execute_stage #(.WIDTH(32), .MD_CYCLES(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_imm(i_imm), .i_busA(i_busA), .i_busB(i_busB), .i_Rw(i_Rw),
        .i_EX(i_EX), .i_M(i_M), .i_WB(i_WB), .o_stall(o_stall),
        .o_valid(o_valid), .o_result(o_result), .o_busB(o_busB), .o_zero(o_zero),
        .o_Rw(o_Rw), .o_M(o_M), .o_WB(o_WB)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference ALU: straight from the opcode table
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [25:0] imm,
                                              input logic src, input logic sx, input logic shsel);
        logic [31:0] opb;
        int          sh;
        opb = src ? (sx ? {{16{imm[15]}}, imm[15:0]} : {16'd0, imm[15:0]}) : b;
        sh  = shsel ? int'(imm[10:6]) : int'(a[4:0]);
        case (op)
            4'd0:    return a + opb;
            4'd1:    return a - opb;
            4'd2:    return a & opb;
            4'd3:    return a | opb;
            4'd4:    return a ^ opb;
            4'd5:    return ~(a | opb);
            4'd6:    return (int'(a) < int'(opb)) ? 32'd1 : 32'd0;
            4'd7:    return (a < opb) ? 32'd1 : 32'd0;
            4'd8:    return b << sh;
            4'd9:    return b >> sh;
            4'd10:   return 32'(int'(b) >>> sh);
            4'd11:   return {imm[15:0], 16'h0000};
            4'd12:   return hi_m;
            4'd13:   return lo_m;
            default: return a;
        endcase
    endfunction

    task automatic drive(input logic valid, input logic flush, input logic [3:0] op,
                         input logic src, input logic sx, input logic shsel, input logic [1:0] md,
                         input logic [25:0] imm, input logic [31:0] a, input logic [31:0] b);
        i_valid = valid;
        i_flush = flush;
        i_EX    = {md, shsel, sx, src, op};
        i_imm   = imm;
        i_busA  = a;
        i_busB  = b;
        i_Rw    = 5'($urandom);
        i_M     = 3'($urandom);
        i_WB    = 1'($urandom);
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [25:0] imm, input logic src, input logic sx, input logic shsel);
        exp_t e;
        drive(1'b1, 1'b0, op, src, sx, shsel, ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, imm, a, b);
        e.res  = model_alu(op, a, b, imm, src, sx, shsel);
        e.busb = b;
        e.zero = (e.res == 32'd0);
        e.rw   = i_Rw;
        e.m    = i_M;
        e.wb   = i_WB;
        exp_q.push_back(e);
        @(posedge i_clk); #1;
    endtask

    task automatic md_run(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] hi_e;
        logic [31:0] lo_e;
        int          cyc;
        exp_t        e;
        if (md == 2'b01) begin
            prod = {32'd0, a} * {32'd0, b};
            hi_e = prod[63:32];
            lo_e = prod[31:0];
        end else if (b == 32'd0) begin
            lo_e = 32'hFFFF_FFFF;
            hi_e = a;
        end else begin
            lo_e = a / b;
            hi_e = a % b;
        end
        drive(1'b1, 1'b0, 4'($urandom), 1'b0, 1'b0, 1'b0, md, 26'($urandom), a, b);
        e.res  = lo_e;
        e.busb = b;
        e.zero = (lo_e == 32'd0);
        e.rw   = i_Rw;
        e.m    = i_M;
        e.wb   = i_WB;
        exp_q.push_back(e);
        #2;
        cyc = 0;
        while (o_stall && cyc < 100) begin
            cyc++;
            @(posedge i_clk); #3;
        end
        check("md_stall_cycles", 64'(cyc), 64'd33);
        hi_m = hi_e;
        lo_m = lo_e;
        @(posedge i_clk); #1;
        check("md_result_at_t34", {31'd0, o_valid, o_result}, {31'd0, 1'b1, lo_e});
        idle();
    endtask

    // Monitor: pop the scoreboard whenever the EX/MEM slot is valid, else check bubble
    always @(negedge i_clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'(o_result), 64'(e.res));
                check("sideband", 64'({o_busB, o_zero, o_Rw, o_M, o_WB}),
                      64'({e.busb, e.zero, e.rw, e.m, e.wb}));
            end
        end else begin
            check("bubble_ctl", 64'({o_M, o_WB}), 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 26'd0, 32'd0, 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_outputs", 64'({o_valid, o_result, o_zero, o_Rw, o_M, o_WB, o_stall}), 64'd0);
        check("reset_busB", 64'(o_busB), 64'd0);
        i_rst = 1'b0;

        alu(4'd0, 32'd7, 32'd9, 26'd0, 1'b0, 1'b0, 1'b0);
        alu(4'd1, 32'd7, 32'd9, 26'd0, 1'b0, 1'b0, 1'b0);
        alu(4'd6, 32'hFFFF_FFFF, 32'd1, 26'd0, 1'b0, 1'b0, 1'b0);
        alu(4'd7, 32'hFFFF_FFFF, 32'd1, 26'd0, 1'b0, 1'b0, 1'b0);
        alu(4'd0, 32'd0, 32'd5, 26'h8000, 1'b1, 1'b1, 1'b0);
        alu(4'd0, 32'd0, 32'd5, 26'h8000, 1'b1, 1'b0, 1'b0);
        alu(4'd11, 32'd3, 32'd5, 26'h1234, 1'b0, 1'b0, 1'b0);
        alu(4'd10, 32'd0, 32'h8000_0000, 26'h0100, 1'b0, 1'b0, 1'b1);
        alu(4'd1, 32'd42, 32'd42, 26'd0, 1'b0, 1'b0, 1'b0);

        // Bubble pass-through with WB requested
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 26'd0, 32'd1, 32'd2);
        i_WB = 1'b1;
        i_M  = 3'd7;
        #2;
        check("bubble_no_stall", 64'(o_stall), 64'd0);
        @(posedge i_clk); #1;
        check("bubble_out", 64'({o_valid, o_M, o_WB}), 64'd0);

        md_run(2'b01, 32'hFFFF_FFFF, 32'd2);
        alu(4'd12, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
        md_run(2'b10, 32'd100, 32'd7);
        alu(4'd12, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
        alu(4'd13, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
        md_run(2'b10, 32'd5, 32'd0);
        alu(4'd12, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);

        // Flush at BUSY iteration 10
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 26'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (11) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        #2;
        check("flush_stall_low", 64'(o_stall), 64'd0);
        @(posedge i_clk); #1;
        check("flush_bubble", 64'(o_valid), 64'd0);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 26'd0, 32'd1, 32'd1);
        #2;
        check("flush_fsm_idle", 64'(o_stall), 64'd0);
        idle();
        alu(4'd12, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
        alu(4'd13, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);

        // Reset during BUSY clears HI/LO and abandons the divide
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b10, 26'd0, 32'd1000, 32'd3);
        repeat (6) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        idle();
        #1;
        check("rst_busy_out", 64'({o_valid, o_result, o_stall}), 64'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        alu(4'd12, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
        alu(4'd13, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            int          sel;
            logic [31:0] a;
            logic [31:0] b;
            sel = $urandom_range(0, 15);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if (sel == 0) begin
                drive(1'b0, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      2'($urandom), 26'($urandom), a, b);
                #2;
                check("rand_bubble_stall", 64'(o_stall), 64'd0);
                @(posedge i_clk); #1;
            end else if (sel == 1) begin
                drive(1'b1, 1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      2'($urandom), 26'($urandom), a, b);
                #2;
                check("rand_flush_stall", 64'(o_stall), 64'd0);
                @(posedge i_clk); #1;
                check("rand_flush_bubble", 64'(o_valid), 64'd0);
            end else if (sel == 2) begin
                if ($urandom_range(0, 2) == 0) begin
                    b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
                end
                md_run(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, a, b);
                alu(4'd12, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
            end else begin
                alu(4'($urandom), a, b, 26'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        idle();
        repeat (3) @(posedge i_clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the pipelined MIPS core. Sits directly downstream of the ID/EX pipeline register.
- Consumes the ID/EX outputs: immediate, busA, busB, Rw, EX/M/WB control.
- Contains a single-cycle ALU, an iterative 32-cycle unsigned multiply/divide unit with HI/LO registers, and the EX/MEM output register.
- Drives a stall to freeze upstream stages while a multiply/divide is in flight.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- MD_CYCLES, 32, iteration count for multiply/divide; must equal WIDTH.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  ID/EX slot holds a real instruction.
- i_flush  in  1  synchronous kill of the current EX instruction and any in-flight multiply/divide.
- i_imm  in  26  immediate field from ID/EX.
- i_busA  in  32  rs operand.
- i_busB  in  32  rt operand.
- i_Rw  in  5  destination register.
- i_EX  in  9  bits [3:0] alu_op; [4] alu_src (1 = immediate); [5] sign-extend imm (0 = zero-extend); [6] shamt from imm[10:6] (0 = from busA[4:0]); [8:7] md_op (00 ALU, 01 MULTU, 10 DIVU, 11 treated as 00).
- i_M  in  3  memory control, passed through.
- i_WB  in  1  writeback enable, passed through.
- o_stall  out  1  upstream must hold ID/EX contents.
- o_valid  out  1  EX/MEM slot valid.
- o_result  out  32  ALU result, or LO for multiply/divide ops.
- o_busB  out  32  store data, registered i_busB.
- o_zero  out  1  registered (result == 0).
- o_Rw  out  5  registered destination.
- o_M  out  3  registered memory control.
- o_WB  out  1  registered writeback enable.

Behaviour:
- Reset (i_rst = 1 at an edge):
  - all outputs 0; HI = LO = 0; FSM to IDLE; iteration counter 0.
  - Reset mid-multiply/divide abandons the operation; HI/LO are not updated.
- Operand B: alu_src ? ext16(imm[15:0]) : busB. ext is sign or zero according to EX[5].
- ALU op codes (combinational):
  - 0 ADD, 1 SUB (wrap-around, no overflow trap)
  - 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU (unsigned)
  - 8 SLL, 9 SRL, 10 SRA: operand busB shifted by shamt
  - 11 LUI = {imm[15:0], 16'h0}
  - 12 MFHI, 13 MFLO: current HI/LO
  - 14, 15: pass busA
- ALU path latency is 1 cycle: inputs at edge N appear on the outputs after edge N.
- The output register captures {valid, result, busB, zero, Rw, M, WB} every cycle in which o_stall = 0.
- Bubble = o_valid, o_M, o_WB all 0; other fields don't-care, but must be deterministic (hold).
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: when i_valid & md_op∈{01,10} & !i_flush. Latch operands, clear counter. o_stall = 1 combinationally in this cycle; output register loads a bubble.
  - BUSY: one radix-2 iteration per cycle.
    - MULTU: shift-add into a 64-bit accumulator.
    - DIVU: restoring divide.
    - o_stall = 1 and a bubble is loaded each cycle.
    - Leave for DONE after MD_CYCLES iterations (counter 0..31).
  - DONE (1 cycle): o_stall = 0.
    - At the edge: HI/LO written, output register captures LO with valid = 1 and i_Rw/i_M/i_WB.
    - FSM returns to IDLE; upstream advances on the same edge.
    - The held MD instruction is never re-triggered.
- Timing: MD accepted in cycle T → BUSY T+1..T+32 → DONE T+33 → o_valid = 1 in T+34. o_stall is high T..T+32, i.e. 33 cycles.
- Results:
  - MULTU: {HI, LO} = busA × busB as a 64-bit unsigned product.
  - DIVU: LO = quotient, HI = remainder. Divide by zero gives LO = 32'hFFFFFFFF, HI = busA.
- i_flush:
  - Has priority over everything except reset.
  - Output register loads a bubble and the FSM goes to IDLE; HI/LO are untouched.
  - o_stall is 0 in the flush cycle.
- i_valid = 0 in IDLE → bubble; no MD start.
- MFHI/MFLO issued in the cycle right after DONE returns the new HI/LO value.

Test Plan:
- ADD, SUB, SLT: busA = 7, busB = 9, alu_op ADD → o_result = 16, o_zero = 0 next cycle. SUB gives 0xFFFFFFFE. SLT(-1, 1) = 1; SLTU(0xFFFFFFFF, 1) = 0.
- Immediate extension: imm[15:0] = 0x8000, ADD with busA = 0: sign-extend → 0xFFFF8000, zero-extend → 0x00008000. LUI 0x1234 → 0x12340000. SRA of 0x80000000 by shamt 4 → 0xF8000000.
- MULTU timing: busA = 0xFFFFFFFF, busB = 2 → o_stall high for exactly 33 cycles. o_valid = 1 at T+34 with o_result = 0xFFFFFFFE. Following MFHI gives 1.
- DIVU: 100 / 7 → LO = 14, HI = 2. Divide by zero: 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- Flush: assert i_flush at BUSY iteration 10 → o_stall = 0 that cycle, bubble out, HI/LO keep prior values, FSM in IDLE. Reset asserted during BUSY gives the same, with HI/LO forced to 0.
- Bubble pass-through: i_valid = 0 with WB = 1 → o_valid = 0, o_WB = 0, o_M = 0, and no stall.
